// File: rtl/logic_cell_cluster.sv
// N-cell 4-LUT cluster with shared FF control and per-cell LUT_FF/ARITH/SHIFT modes; FZ/CO combinational, QZ one cycle.
// Define LOGIC_CLUSTER_CFG_CHAIN_EN for serial LUT reload; CFG_BUSY freezes all cell FFs while loading.
module logic_cell_cluster #(
  parameter int                      N_CELLS   = 8,
  parameter logic [16*N_CELLS-1:0]   LUT_INIT  = '0,
  parameter logic [2*N_CELLS-1:0]    CELL_MODE = '0
) (
  input  logic                   QCK,
  input  logic                   QRT,
  input  logic                   QEN,
  input  logic                   QST,
  input  logic [4*N_CELLS-1:0]   LI,
  input  logic                   CI,
  output logic [N_CELLS-1:0]     FZ,
  output logic [N_CELLS-1:0]     QZ,
  output logic                   CO,
  input  logic                   CFG_START,
  input  logic                   CFG_DI,
  output logic                   CFG_DO,
  output logic                   CFG_BUSY,
  output logic                   CFG_DONE
);

  localparam int LUT_BITS = 16 * N_CELLS;
  localparam int CNT_W    = $clog2(LUT_BITS + 1);

  logic [LUT_BITS-1:0] lut;
  logic                busy;

`ifdef LOGIC_CLUSTER_CFG_CHAIN_EN
  typedef enum logic [1:0] {IDLE, LOAD, DONE} cfg_state_t;

  cfg_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             done;

  always_ff @(posedge QCK or posedge QRT) begin
    if (QRT) begin
      state <= IDLE;
      cnt   <= '0;
      lut   <= LUT_INIT;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (CFG_START) begin
          state <= LOAD;
          cnt   <= '0;
          busy  <= 1'b1;
        end
        LOAD: begin
          lut <= {CFG_DI, lut[LUT_BITS-1:1]};
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(LUT_BITS - 1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign CFG_BUSY = busy;
  assign CFG_DONE = done;
  assign CFG_DO   = lut[0];
`else
  logic cfg_unused;

  assign lut        = LUT_INIT;
  assign busy       = 1'b0;
  assign CFG_BUSY   = 1'b0;
  assign CFG_DONE   = 1'b0;
  assign CFG_DO     = LUT_INIT[0];
  assign cfg_unused = CFG_START ^ CFG_DI;
`endif

  logic [N_CELLS:0]   carry;
  logic [N_CELLS-1:0] p;
  logic [N_CELLS-1:0] fz;
  logic [N_CELLS-1:0] d;
  logic [N_CELLS-1:0] shift_src;
  logic [15:0]        cell_lut;

  // Shift cells take the previous cell's QZ; cell 0 takes LI[0].
  assign shift_src = N_CELLS'({QZ, LI[0]});

  always_comb begin
    carry    = '0;
    carry[0] = CI;
    p        = '0;
    fz       = '0;
    d        = '0;
    cell_lut = '0;
    for (int i = 0; i < N_CELLS; i++) begin
      cell_lut = lut[16*i +: 16];
      p[i]     = cell_lut[LI[4*i +: 4]];
      case (CELL_MODE[2*i +: 2])
        2'b01: begin
          fz[i]      = p[i] ^ carry[i];
          d[i]       = fz[i];
          carry[i+1] = p[i] ? carry[i] : LI[4*i+1];
        end
        2'b10: begin
          fz[i]      = p[i];
          d[i]       = shift_src[i];
          carry[i+1] = carry[i];
        end
        default: begin
          fz[i]      = p[i];
          d[i]       = p[i];
          carry[i+1] = carry[i];
        end
      endcase
    end
  end

  assign FZ = fz;
  assign CO = carry[N_CELLS];

  always_ff @(posedge QCK or posedge QRT) begin
    if (QRT) begin
      QZ <= '0;
    end else if (!busy) begin
      if (QST) begin
        QZ <= '1;
      end else if (QEN) begin
        QZ <= d;
      end
    end
  end

endmodule

// File: tb/tb_logic_cell_cluster.sv
// Randomized bench for logic_cell_cluster against a behavioural model, plus hand-computed checks.
module tb_logic_cell_cluster;

  localparam int N  = 8;
  localparam int LB = 16 * N;
  localparam logic [127:0] INIT = {16'h1234, 16'hF0F0, 16'h00FF, 16'h6666,
                                   16'h6666, 16'h6666, 16'hA5C3, 16'h8000};
  // cells 7..5 SHIFT, 4..2 ARITH, cell 1 mode 11 (plain), cell 0 LUT_FF
  localparam logic [15:0] MODE = 16'hA95C;

  logic        QCK = 1'b0, QRT = 1'b1, QEN = 1'b0, QST = 1'b0, CI = 1'b0;
  logic        CFG_START = 1'b0, CFG_DI = 1'b0;
  logic [31:0] LI = '0;
  logic [7:0]  FZ, QZ;
  logic        CO, CFG_DO, CFG_BUSY, CFG_DONE;

  logic_cell_cluster #(.N_CELLS(N), .LUT_INIT(INIT), .CELL_MODE(MODE)) dut (
    .QCK(QCK), .QRT(QRT), .QEN(QEN), .QST(QST), .LI(LI), .CI(CI),
    .FZ(FZ), .QZ(QZ), .CO(CO),
    .CFG_START(CFG_START), .CFG_DI(CFG_DI), .CFG_DO(CFG_DO),
    .CFG_BUSY(CFG_BUSY), .CFG_DONE(CFG_DONE)
  );

  always #5 QCK = ~QCK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_eval(input logic [127:0] lut, input logic [31:0] li,
                                     input logic ci, input logic [7:0] qz,
                                     output logic [7:0] fz, output logic co,
                                     output logic [7:0] d);
    logic [15:0] mv = MODE;
    logic [8:0]  prev = {qz, li[0]};
    logic        c = ci;
    fz = '0;
    d  = '0;
    for (int i = 0; i < N; i++) begin
      int   idx  = int'(li[4*i +: 4]);
      int   mode = int'(mv[2*i +: 2]);
      logic pv   = lut[16*i + idx];
      if (mode == 1) begin
        fz[i] = pv ^ c;
        d[i]  = fz[i];
        c     = pv ? c : li[4*i+1];
      end else if (mode == 2) begin
        fz[i] = pv;
        d[i]  = prev[i];
      end else begin
        fz[i] = pv;
        d[i]  = pv;
      end
    end
    co = c;
  endfunction

  logic [127:0] m_lut = INIT;
  logic [7:0]   m_qz = '0;
  int           m_rem = 0;
  bit           m_done = 1'b0;
  logic [7:0]   m_fz_unused, m_d;
  logic         m_co_unused;

  always @(posedge QCK or posedge QRT) begin
    if (QRT) begin
      m_lut  = INIT;
      m_qz   = '0;
      m_rem  = 0;
      m_done = 1'b0;
    end else begin
      model_eval(m_lut, LI, CI, m_qz, m_fz_unused, m_co_unused, m_d);
      if (m_rem == 0) begin
        if (QST) m_qz = '1;
        else if (QEN) m_qz = m_d;
      end
`ifdef LOGIC_CLUSTER_CFG_CHAIN_EN
      if (m_rem > 0) begin
        m_lut = {CFG_DI, m_lut[127:1]};
        m_rem--;
        if (m_rem == 0) m_done = 1'b1;
      end else if (m_done) begin
        m_done = 1'b0;
      end else if (CFG_START) begin
        m_rem = LB;
      end
`endif
    end
  end

  bit         started = 1'b0;
  logic [7:0] e_fz, e_d_unused;
  logic       e_co;

  always @(negedge QCK) begin
    if (started) begin
      model_eval(m_lut, LI, CI, m_qz, e_fz, e_co, e_d_unused);
      check("fz", FZ, e_fz);
      check("qz", QZ, m_qz);
      check("co", CO, e_co);
      check("busy", CFG_BUSY, m_rem > 0);
      check("done", CFG_DONE, m_done);
      check("do", CFG_DO, m_lut[0]);
    end
  end

  task automatic drive_li(input logic [31:0] v, input logic c);
    @(posedge QCK); #1;
    LI = v;
    CI = c;
    @(negedge QCK);
  endtask

  logic [3:0] exp_sh [4] = '{4'hE, 4'hC, 4'h8, 4'h0};

  initial begin
    @(posedge QCK); #1;
    started = 1'b1;
    @(negedge QCK);
    check("rst_qz", QZ, 8'h00);
    check("rst_fz", FZ, 8'h22);
    check("rst_co", CO, 1'b0);
    check("rst_busy", CFG_BUSY, 1'b0);
    check("rst_do", CFG_DO, 1'b0);
    @(posedge QCK); #1;
    QRT = 1'b0;

    // AND4 in cell 0
    QEN = 1'b1;
    drive_li(32'h0000_000F, 1'b0);
    check("and4_fz_on", FZ[0], 1'b1);
    drive_li(32'h0000_000E, 1'b0);
    check("and4_qz", QZ[0], 1'b1);
    check("and4_fz_off", FZ[0], 1'b0);

    // ripple carry through cells 2..4 (A in bit 4i, B in bit 4i+1)
    drive_li(32'h0001_1100, 1'b1);
    check("arith_prop_fz", FZ[4:2], 3'b000);
    check("arith_prop_co", CO, 1'b1);
    drive_li(32'h0001_1100, 1'b0);
    check("arith_noc_fz", FZ[4:2], 3'b111);
    check("arith_noc_co", CO, 1'b0);
    drive_li(32'h0003_3300, 1'b0);
    check("arith_gen_fz", FZ[4:2], 3'b110);
    check("arith_gen_co", CO, 1'b1);

    // set beats enable, then hold
    @(posedge QCK); #1;
    LI = '0; CI = 1'b0; QST = 1'b1; QEN = 1'b1;
    @(posedge QCK); #1;
    QST = 1'b0; QEN = 1'b0;
    @(negedge QCK);
    check("qst_set", QZ, 8'hFF);
    repeat (3) @(posedge QCK);
    @(negedge QCK);
    check("qz_hold", QZ, 8'hFF);

    // zero from cell 4 walks up the shift cells
    @(posedge QCK); #1;
    QEN = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge QCK);
      @(negedge QCK);
      check("shift_seq", QZ[7:4], exp_sh[k]);
    end

`ifdef LOGIC_CLUSTER_CFG_CHAIN_EN
    begin
      logic [127:0] pat;
      logic [7:0]   qz0;
      int busy_cnt = 0, first_busy = 0, done_c = 0;
      bit qz_moved = 1'b0;
      pat = INIT;
      pat[15:0] = 16'h0001;
      @(posedge QCK); #1;
      CFG_START = 1'b1; QST = 1'b1; QEN = 1'b1;
      @(posedge QCK); #1;
      CFG_START = 1'b0;
      qz0 = 8'hFF;
      for (int c = 1; c <= 200; c++) begin
        @(negedge QCK);
        if (CFG_BUSY === 1'b1) begin
          busy_cnt++;
          if (first_busy == 0) first_busy = c;
          if (QZ !== qz0) qz_moved = 1'b1;
        end
        if (CFG_DONE === 1'b1 && done_c == 0) done_c = c;
        CFG_DI = (c <= LB) ? pat[c-1] : 1'b0;
        QST = ($urandom_range(1) == 1);
        LI = $urandom;
      end
      check("load_busy_cycles", busy_cnt, LB);
      check("load_first_busy", first_busy, 1);
      check("load_done_cycle", done_c, LB + 1);
      check("load_qz_frozen", qz_moved, 1'b0);
      QST = 1'b0; QEN = 1'b0;
      drive_li(32'h0, 1'b0);
      check("reload_cell0", FZ[0], 1'b1);
      check("reload_do", CFG_DO, 1'b1);

      @(posedge QCK); #1;
      CFG_START = 1'b1;
      @(posedge QCK); #1;
      CFG_START = 1'b0;
      repeat (10) begin
        @(posedge QCK); #1;
        CFG_DI = $urandom_range(1);
      end
      LI = '0;
      QRT = 1'b1;
      #2;
      check("abort_busy", CFG_BUSY, 1'b0);
      check("abort_do", CFG_DO, 1'b0);
      check("abort_fz", FZ, 8'h22);
      @(posedge QCK); #1;
      QRT = 1'b0;
    end
`endif

    for (int c = 0; c < 2500; c++) begin
      @(posedge QCK); #1;
      QRT       = (!QRT) && ($urandom_range(399) == 0);
      LI        = $urandom;
      CI        = $urandom_range(1);
      QEN       = $urandom_range(1);
      QST       = ($urandom_range(7) == 0);
      CFG_START = ($urandom_range(63) == 0);
      CFG_DI    = $urandom_range(1);
    end
    @(negedge QCK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/logic_cell_cluster.md
# logic_cell_cluster

Parametrised successor to the fixed eight-cell super logic cell. It provides an N-cell cluster of 4-input LUT cells sharing one register control set. Each cell has a per-cell mode (plain LUT+FF, arithmetic with ripple carry, or shift register), and the cluster supports optional runtime serial reload of LUT contents. It sits in the ap3 logic tile wherever a CLB-column primitive is instantiated, and drives the tile routing with combinational and registered outputs.

## Interface
Parameters:
- N_CELLS, 8, number of cells (1..32); carry chain length.
- LUT_INIT, {16*N_CELLS{1'b0}}, LUT truth tables; bits [16i+15:16i] belong to cell i.
- CELL_MODE, {2*N_CELLS{1'b0}}, per-cell mode in bits [2i+1:2i]: 00 LUT_FF, 01 ARITH, 10 SHIFT, 11 treated as LUT_FF.

Ports:
- QCK  in  1  cluster clock, rising edge.
- QRT  in  1  reset, asynchronous, active-high.
- QEN  in  1  register enable, shared by all cells.
- QST  in  1  synchronous set, shared; sets all cell FFs to 1.
- LI  in  4*N_CELLS  LUT inputs; LI[4i+3:4i] feed cell i.
- CI  in  1  carry into cell 0.
- FZ  out  N_CELLS  combinational cell outputs.
- QZ  out  N_CELLS  registered cell outputs.
- CO  out  1  carry out of cell N_CELLS-1.
- CFG_START  in  1  one-cycle request to begin a LUT reload.
- CFG_DI  in  1  serial LUT data.
- CFG_DO  out  1  serial readback, equal to lut[0].
- CFG_BUSY  out  1  high while loading.
- CFG_DONE  out  1  one-cycle pulse when a load completes.

## Operation
- Cell i: idx = LI[4i+3:4i]; P_i = lut[16i+idx]; cin_0 = CI, cin_i = cout_{i-1}; CO = cout_{N-1}.
- LUT_FF: FZ_i = P_i, D_i = P_i, cout_i = cin_i (carry passes through).
- ARITH: FZ_i = P_i ^ cin_i, D_i = FZ_i, cout_i = P_i ? cin_i : LI[4i+1].
- SHIFT: FZ_i = P_i, D_0 = LI[0], D_i = QZ_{i-1} for i>0, cout_i = cin_i.
- FF priority on each QCK rise: CFG_BUSY holds all FFs; else QST sets the FF to 1; else QEN loads D_i; else the FF holds.
- Config FSM with states IDLE, LOAD, DONE:
  - IDLE: CFG_START=1 moves to LOAD and clears the bit counter.
  - LOAD: each cycle, lut <= {CFG_DI, lut[16N-1:1]} and the counter increments. After 16*N_CELLS shifts, move to DONE. CFG_START is ignored while in LOAD.
  - DONE: CFG_DONE=1 for one cycle, then IDLE. A CFG_START arriving in DONE is ignored.
- During LOAD, FZ and CO follow the live, partially shifted LUT contents. This is defined behaviour; users must not sample them.
- The counter is ceil(log2(16*N_CELLS+1)) bits wide and does not wrap within a load.

## Timing
- Reset values while QRT=1: QZ=0, lut=LUT_INIT, FSM=IDLE, counter=0, CFG_BUSY=0, CFG_DONE=0, CFG_DO=LUT_INIT[0]. FZ and CO are combinational from LUT_INIT.
- QRT asserted mid-load aborts the load and restores LUT_INIT immediately. Deassertion is synchronised by the tile; the block assumes a clean release.
- FZ and CO are combinational, with zero-cycle latency. QZ updates one cycle after its inputs are sampled.
- CFG_START sampled high at edge k: CFG_BUSY is high from k+1 through k+16N. The shifts occur at edges k+1..k+16N, CFG_DONE is high in cycle k+16N+1, and a new CFG_START is accepted from edge k+16N+2.
- QST together with QEN: the set wins. QST during BUSY: the FF holds.

## Configuration
- LOGIC_CLUSTER_CFG_CHAIN_EN defined: LUT storage is a register chain, and the FSM, counter and CFG_* ports behave as above.
- Not defined: LUTs are the constant LUT_INIT. CFG_START and CFG_DI are ignored, CFG_BUSY=CFG_DONE=0, CFG_DO=LUT_INIT[0], and the FFs never hold for configuration.

## Test plan
- Reset: N=8, LUT_INIT all-ones, QRT pulse mid-stream -> QZ=8'h00, FZ=8'hFF, CFG_BUSY=0.
- LUT_FF: cell 0 LUT_INIT=16'h8000 (AND4), LI[3:0]=4'hF, QEN=1 -> FZ[0]=1, QZ[0]=1 one edge later; LI[3:0]=4'hE -> FZ[0]=0.
- ARITH adder: all cells ARITH, P=XOR of LI[4i+0] and LI[4i+1] (LUT 16'h6666), A=8'hFF in LI[4i+0], B=8'h01 in LI[4i+1], CI=0 -> FZ=8'h00, CO=1; QZ=8'h00 after the QEN edge.
- SHIFT: all cells SHIFT, QEN=1, LI[0]=1 for one cycle then 0 -> QZ sequence 01,02,04,...,80, then 00.
- QST/QEN priority: QST=1 and QEN=1 with D=0 -> QZ=8'hFF; QST=0, QEN=0 -> QZ holds 8'hFF.
- Reload (macro defined, N=2): CFG_START, then shift 32 bits equal to 32'h0000_8000 LSB-first -> CFG_BUSY high for 32 cycles, CFG_DONE pulses at cycle 33; cell 0 then behaves as AND4 and QZ held constant throughout the load; QRT at shift 10 restores LUT_INIT.
